pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline stall/flush scheduler for the 5-stage core. Collects hazard and wait conditions
//  (load-use in ID, multi-cycle ops in EX, bus waits in MEM, exception flush) and drives one
//  stall vector that freezes stages PC..k and inserts a bubble into stage k+1. Sits beside
//  the pipeline registers; ID forwarding covers everything except load-use, resolved here.
// PARAMETERS
//  CNT_W        6    width of the EX multi-cycle counter (max op length 2^CNT_W-1)
//  MEM_TIMEOUT  255  consecutive MEM-wait cycles before mem_timeout_o is set
//  TO_W         8    width of the MEM-wait counter (>= clog2(MEM_TIMEOUT+1))
//  PERF_W       32   width of the stall-cycle performance counter
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       reset; rst is synchronous, active-high
//  flush_i         in   1       exception/redirect: abort all waits this cycle
//  id_reg1_read_i  in   1       ID reads operand 1 from regfile
//  id_reg1_addr_i  in   5       ID operand 1 address
//  id_reg2_read_i  in   1       ID reads operand 2 from regfile
//  id_reg2_addr_i  in   5       ID operand 2 address
//  ex_is_load_i    in   1       instruction in EX is a load
//  ex_wreg_i       in   1       instruction in EX writes a register
//  ex_wd_i         in   5       EX destination register
//  ex_mc_start_i   in   1       EX begins a multi-cycle op (1-cycle pulse)
//  ex_mc_cycles_i  in   CNT_W   total EX occupancy N of that op
//  mem_req_i       in   1       MEM stage has an outstanding bus access (level)
//  mem_ack_i       in   1       bus completes the access this cycle
//  stall_o         out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
//  flush_o         out  1       clear IF/ID/EX/MEM pipeline registers
//  ex_mc_busy_o    out  1       multi-cycle op in progress
//  ex_mc_last_o    out  1       final EX cycle of multi-cycle op; result valid
//  mem_timeout_o   out  1       sticky: MEM wait exceeded MEM_TIMEOUT
//  stall_cnt_o     out  PERF_W  saturating count of cycles with stall_o != 0
// BEHAVIOUR
//  - Reset: stall_o=0, flush_o=0, ex_mc_busy_o=0, ex_mc_last_o=0, mem_timeout_o=0,
//    stall_cnt_o=0, FSM=IDLE, counters=0. Reset mid-op discards the op, no ex_mc_last_o.
//  - load_use = ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i)
//    | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)); combinational, one cycle per occurrence.
//  - mem_stall = mem_req_i & ~mem_ack_i (combinational; ack cycle itself is not stalled).
//  - EX FSM IDLE/BUSY. IDLE: ex_mc_start_i & ~mem_stall & N>=2 -> stall this cycle,
//    cnt<=N-2, BUSY. N<2 -> no stall, stay IDLE. BUSY: cnt==0 -> ex_mc_last_o=1, no EX stall,
//    -> IDLE; else EX stall, cnt<=cnt-1. cnt holds while mem_stall=1. Start in BUSY ignored.
//    Example N=3 starting cycle t: stall t,t+1; ex_mc_last_o at t+2.
//  - Priority (highest first): flush_i > mem_stall > EX busy/start > load_use.
//    flush_i: stall_o=0, flush_o=1 same cycle, FSM->IDLE, MEM-wait counter cleared.
//    mem_stall: stall_o=6'b011111. EX: 6'b001111. load_use: 6'b000111. none: 6'b000000.
//  - MEM-wait counter: +1 per mem_stall cycle (saturating), cleared when mem_stall=0;
//    reaching MEM_TIMEOUT sets mem_timeout_o; cleared only by rst or flush_i.
//  - stall_cnt_o: +1 each cycle stall_o!=0, saturates at all-ones, cleared by rst only.
//  - ex_mc_busy_o = (FSM==BUSY). All registered state updates on rising clk.
// STRUCTURE
//  - precompiled.v: `StallBus 5:0, stage-bit indices, stall pattern constants
//    (`StallNone/`StallLoadUse/`StallEx/`StallMem), FSM state encodings.
//  - One sub-module: ctrl_down_counter (load, dec-enable, hold, zero flag) for the EX count.
//  - Stall-vector priority mux and MEM-wait/perf counters stay inline.
// TESTING
//  - ex_is_load=1,ex_wreg=1,ex_wd=5; id_reg2_read=1,addr=5 -> stall_o=000111 one cycle; wd=0 -> 0.
//  - ex_mc_start with N=4 at t -> stall_o=001111 at t..t+2, ex_mc_last_o=1 at t+3, busy t+1..t+3.
//  - N=4 start, mem_req held 2 cycles during BUSY -> stall_o=011111 those cycles, last delayed by 2.
//  - mem_req=1,ack=0 for 255 cycles (MEM_TIMEOUT=255) -> mem_timeout_o=1 after; flush_i clears it.
//  - flush_i during BUSY + mem_stall -> stall_o=0, flush_o=1, next cycle busy=0, no last pulse.
//  - rst asserted mid-BUSY -> all outputs 0 next cycle; stall_cnt_o counts exactly stalled cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush scheduler: stall-vector layout,
// stall patterns and the EX multi-cycle FSM state type.
package pipe_ctrl_pkg;

  // Stall vector width: one bit per stage, PC through WB.
  localparam int unsigned STALL_W = 6;

  // Stage bit positions inside the stall vector.
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  // Register address width of the core.
  localparam int unsigned REG_AW = 5;

  // Mask that holds stages PC..stg; the stage after stg receives a bubble.
  function automatic logic [STALL_W-1:0] stall_through(input int unsigned stg);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < STALL_W; i++) begin
      m[i] = (i <= stg);
    end
    return m;
  endfunction

  localparam logic [STALL_W-1:0] STALL_NONE     = '0;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = stall_through(STG_ID);
  localparam logic [STALL_W-1:0] STALL_EX       = stall_through(STG_EX);
  localparam logic [STALL_W-1:0] STALL_MEM      = stall_through(STG_MEM);

  // EX multi-cycle operation tracker.
  typedef enum logic {
    EX_IDLE = 1'b0,
    EX_BUSY = 1'b1
  } ex_state_e;

endpackage

// File: rtl/pipe_ctrl_down_counter.sv
// Loadable down counter with hold and zero flag; tracks the remaining EX
// occupancy of a multi-cycle operation.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (pipeline flush)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; count holds when dec is low
//   count     : current count (registered)
//   zero_c    : count == 0 (combinational decode of the register)
module pipe_ctrl_down_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  // Count register: clear > load > decrement > hold.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler for the 5-stage core. Merges exception flush,
// MEM bus waits, EX multi-cycle occupancy and ID load-use hazards into one
// stall vector (hold PC..k, bubble into k+1) and keeps MEM-timeout and
// stall-cycle statistics.
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : exception/redirect, aborts all waits this cycle
//   id_reg*_read_i/addr_i : ID operand reads
//   ex_is_load_i, ex_wreg_i, ex_wd_i : EX instruction destination info
//   ex_mc_start_i, ex_mc_cycles_i    : start pulse and total length of a multi-cycle op
//   mem_req_i, mem_ack_i             : MEM outstanding access / completion
//   stall_o           : [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold (same-cycle)
//   flush_o           : clear IF/ID/EX/MEM pipeline registers (same-cycle)
//   ex_mc_busy_o      : multi-cycle op in progress
//   ex_mc_last_o      : final advancing EX cycle of the op, result valid
//   mem_timeout_o     : sticky MEM-wait timeout
//   stall_cnt_o       : saturating count of stalled cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              id_reg1_read_i,
  input  logic [4:0]        id_reg1_addr_i,
  input  logic              id_reg2_read_i,
  input  logic [4:0]        id_reg2_addr_i,
  input  logic              ex_is_load_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic              ex_mc_start_i,
  input  logic [CNT_W-1:0]  ex_mc_cycles_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              ex_mc_busy_o,
  output logic              ex_mc_last_o,
  output logic              mem_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  ex_state_e          state_q;
  logic [CNT_W-1:0]   mc_cnt;
  logic               mc_zero_c;
  logic [TO_W-1:0]    wait_q;
  logic [TO_W-1:0]    wait_inc_c;

  logic               mem_stall_c;
  logic               load_use_c;
  logic               busy_c;
  logic               mc_start_ok_c;
  logic               ex_stall_c;
  logic               mc_load_c;
  logic               mc_dec_c;
  logic [STALL_W-1:0] stall_c;

  // Bus wait: the ack cycle itself completes and is not stalled.
  assign mem_stall_c = mem_req_i & ~mem_ack_i;

  // Load result is not forwardable to ID in time; r0 never creates a hazard.
  assign load_use_c = ex_is_load_i & ex_wreg_i & (ex_wd_i != REG_AW'(0)) &
                      ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
                       (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));

  assign busy_c = (state_q == EX_BUSY);

  // Ops shorter than two cycles behave like single-cycle EX and need no tracking.
  assign mc_start_ok_c = ~busy_c & ex_mc_start_i & ~mem_stall_c &
                         (ex_mc_cycles_i >= CNT_W'(2));

  // EX holds on the start cycle and on every busy cycle except the last.
  assign ex_stall_c = mc_start_ok_c | (busy_c & ~mc_zero_c);

  // Counter control: a MEM stall freezes EX, so the count holds.
  assign mc_load_c = mc_start_ok_c & ~flush_i;
  assign mc_dec_c  = busy_c & ~mc_zero_c & ~mem_stall_c & ~flush_i;

  pipe_ctrl_down_counter #(
    .W (CNT_W)
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .load     (mc_load_c),
    .load_val (ex_mc_cycles_i - CNT_W'(2)),
    .dec      (mc_dec_c),
    .count    (mc_cnt),
    .zero_c   (mc_zero_c)
  );

  // Stall priority: flush > MEM wait > EX occupancy > load-use.
  always_comb begin
    stall_c = STALL_NONE;
    if (rst || flush_i) begin
      stall_c = STALL_NONE;
    end else if (mem_stall_c) begin
      stall_c = STALL_MEM;
    end else if (ex_stall_c) begin
      stall_c = STALL_EX;
    end else if (load_use_c) begin
      stall_c = STALL_LOAD_USE;
    end
  end

  assign stall_o      = stall_c;
  assign flush_o      = flush_i & ~rst;
  assign ex_mc_busy_o = busy_c & ~rst;
  // The final cycle only counts once EX actually advances out of it.
  assign ex_mc_last_o = busy_c & mc_zero_c & ~mem_stall_c & ~flush_i & ~rst;

  // EX multi-cycle FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EX_IDLE;
    end else if (flush_i) begin
      state_q <= EX_IDLE;
    end else begin
      case (state_q)
        EX_IDLE: begin
          if (mc_start_ok_c) begin
            state_q <= EX_BUSY;
          end
        end
        EX_BUSY: begin
          if (mc_zero_c && !mem_stall_c) begin
            state_q <= EX_IDLE;
          end
        end
        default: state_q <= EX_IDLE;
      endcase
    end
  end

  // Saturating increment of the consecutive MEM-wait count.
  assign wait_inc_c = (wait_q == {TO_W{1'b1}}) ? wait_q : (wait_q + TO_W'(1));

  // MEM-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wait_q        <= '0;
      mem_timeout_o <= 1'b0;
    end else if (mem_stall_c) begin
      wait_q <= wait_inc_c;
      if (wait_inc_c >= TIMEOUT_VAL) begin
        mem_timeout_o <= 1'b1;
      end
    end else begin
      wait_q <= '0;
    end
  end

  // Saturating stalled-cycle performance counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((stall_c != STALL_NONE) && (stall_cnt_o != {PERF_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the scheduling rules.
module tb_pipe_ctrl;

  localparam int MEM_TIMEOUT = 255;
  localparam int RAND_CYCLES = 4000;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_is_load_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_mc_start_i;
  logic [5:0]  ex_mc_cycles_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        ex_mc_busy_o;
  logic        ex_mc_last_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(
    .CNT_W       (6),
    .MEM_TIMEOUT (255),
    .TO_W        (8),
    .PERF_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_cycles_i (ex_mc_cycles_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .ex_mc_busy_o   (ex_mc_busy_o),
    .ex_mc_last_o   (ex_mc_last_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. m_rem = EX cycles the current op still needs to
  // advance through (0 = no op); the op is done on the cycle m_rem is 1.
  // ---------------------------------------------------------------------
  int   m_rem  = 0;
  int   m_wait = 0;
  int   m_scnt = 0;
  logic m_to   = 1'b0;

  always @(negedge clk) begin
    logic       ms, lu, bsy, sok, ex, lst;
    logic [5:0] es;
    int         n;
    n   = int'(ex_mc_cycles_i);
    ms  = mem_req_i && !mem_ack_i;
    lu  = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
          ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
           (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
    bsy = (m_rem > 0);
    sok = !bsy && ex_mc_start_i && !ms && (n >= 2);
    ex  = sok || (m_rem > 1);
    lst = bsy && (m_rem == 1) && !ms && !flush_i;
    if (flush_i)  es = 6'b000000;
    else if (ms)  es = 6'b011111;
    else if (ex)  es = 6'b001111;
    else if (lu)  es = 6'b000111;
    else          es = 6'b000000;
    if (rst) begin
      es  = 6'b000000;
      lst = 1'b0;
      bsy = 1'b0;
    end

    chk("m_stall",   32'(stall_o),       32'(es));
    chk("m_flush",   32'(flush_o),       32'(flush_i && !rst));
    chk("m_busy",    32'(ex_mc_busy_o),  32'(bsy));
    chk("m_last",    32'(ex_mc_last_o),  32'(lst));
    chk("m_timeout", 32'(mem_timeout_o), 32'(m_to));
    chk("m_scnt",    stall_cnt_o,        32'(m_scnt));

    // advance model to the next cycle
    if (rst) begin
      m_rem = 0; m_wait = 0; m_to = 1'b0; m_scnt = 0;
    end else begin
      if (es != 6'b000000) m_scnt++;
      if (flush_i) begin
        m_rem = 0; m_wait = 0; m_to = 1'b0;
      end else begin
        if (sok) m_rem = n - 1;
        else if (bsy && !ms) m_rem--;
        if (ms) begin
          m_wait = (m_wait < 255) ? m_wait + 1 : 255;
          if (m_wait >= MEM_TIMEOUT) m_to = 1'b1;
        end else begin
          m_wait = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i = 0; id_reg1_read_i = 0; id_reg1_addr_i = 0;
    id_reg2_read_i = 0; id_reg2_addr_i = 0; ex_is_load_i = 0; ex_wreg_i = 0;
    ex_wd_i = 0; ex_mc_start_i = 0; ex_mc_cycles_i = 0; mem_req_i = 0; mem_ack_i = 0;
  endtask

  // Check stall/busy/last literals in the current cycle, then move on.
  task automatic expect3(input string name, input logic [5:0] s, input logic b, input logic l);
    @(negedge clk);
    chk({name, "_stall"}, 32'(stall_o), 32'(s));
    chk({name, "_busy"},  32'(ex_mc_busy_o), 32'(b));
    chk({name, "_last"},  32'(ex_mc_last_o), 32'(l));
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();

    // reset state
    @(negedge clk);
    chk("rst_stall",   32'(stall_o),       32'h0);
    chk("rst_flush",   32'(flush_o),       32'h0);
    chk("rst_busy",    32'(ex_mc_busy_o),  32'h0);
    chk("rst_last",    32'(ex_mc_last_o),  32'h0);
    chk("rst_timeout", 32'(mem_timeout_o), 32'h0);
    chk("rst_scnt",    stall_cnt_o,        32'h0);
    next_cycle();
    rst = 1'b0;

    // load-use hazard, then same pattern against r0
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5; id_reg2_read_i = 1; id_reg2_addr_i = 5;
    expect3("lu", 6'b000111, 0, 0);
    ex_wd_i = 0; id_reg2_addr_i = 0;
    expect3("lu_r0", 6'b000000, 0, 0);
    clear_inputs();

    // N=4 multi-cycle op
    ex_mc_start_i = 1; ex_mc_cycles_i = 4;
    expect3("mc4_t0", 6'b001111, 0, 0);
    ex_mc_start_i = 0;
    expect3("mc4_t1", 6'b001111, 1, 0);
    expect3("mc4_t2", 6'b001111, 1, 0);
    expect3("mc4_t3", 6'b000000, 1, 1);
    expect3("mc4_t4", 6'b000000, 0, 0);

    // N=4 with a two-cycle MEM wait during BUSY
    ex_mc_start_i = 1; ex_mc_cycles_i = 4;
    expect3("mcm_t0", 6'b001111, 0, 0);
    ex_mc_start_i = 0; mem_req_i = 1;
    expect3("mcm_t1", 6'b011111, 1, 0);
    expect3("mcm_t2", 6'b011111, 1, 0);
    mem_req_i = 0;
    expect3("mcm_t3", 6'b001111, 1, 0);
    expect3("mcm_t4", 6'b001111, 1, 0);
    expect3("mcm_t5", 6'b000000, 1, 1);
    expect3("mcm_t6", 6'b000000, 0, 0);

    // MEM timeout after 255 consecutive wait cycles; flush clears it
    mem_req_i = 1; mem_ack_i = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      if (i == MEM_TIMEOUT - 1) chk("to_before", 32'(mem_timeout_o), 32'h0);
      next_cycle();
    end
    mem_req_i = 0;
    @(negedge clk);
    chk("to_set", 32'(mem_timeout_o), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("to_sticky", 32'(mem_timeout_o), 32'h1);
    next_cycle();
    flush_i = 1;
    @(negedge clk);
    chk("to_flush_o", 32'(flush_o), 32'h1);
    next_cycle();
    flush_i = 0;
    @(negedge clk);
    chk("to_cleared", 32'(mem_timeout_o), 32'h0);
    next_cycle();

    // flush during BUSY with a MEM wait
    ex_mc_start_i = 1; ex_mc_cycles_i = 5;
    expect3("fl_t0", 6'b001111, 0, 0);
    ex_mc_start_i = 0; mem_req_i = 1; flush_i = 1;
    @(negedge clk);
    chk("fl_stall", 32'(stall_o), 32'h0);
    chk("fl_flush", 32'(flush_o), 32'h1);
    chk("fl_last",  32'(ex_mc_last_o), 32'h0);
    next_cycle();
    flush_i = 0; mem_req_i = 0;
    expect3("fl_t2", 6'b000000, 0, 0);
    expect3("fl_t3", 6'b000000, 0, 0);

    // exact stall-cycle count after a fresh reset
    rst = 1;
    next_cycle();
    rst = 0;
    ex_mc_start_i = 1; ex_mc_cycles_i = 3;
    expect3("sc_t0", 6'b001111, 0, 0);
    ex_mc_start_i = 0;
    expect3("sc_t1", 6'b001111, 1, 0);
    expect3("sc_t2", 6'b000000, 1, 1);
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 7; id_reg1_read_i = 1; id_reg1_addr_i = 7;
    expect3("sc_lu", 6'b000111, 0, 0);
    clear_inputs();
    @(negedge clk);
    chk("sc_count", stall_cnt_o, 32'd3);
    next_cycle();

    // reset in the middle of BUSY
    ex_mc_start_i = 1; ex_mc_cycles_i = 6;
    expect3("rb_t0", 6'b001111, 0, 0);
    ex_mc_start_i = 0;
    expect3("rb_t1", 6'b001111, 1, 0);
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("rb_busy",  32'(ex_mc_busy_o), 32'h0);
    chk("rb_last",  32'(ex_mc_last_o), 32'h0);
    chk("rb_stall", 32'(stall_o),      32'h0);
    chk("rb_scnt",  stall_cnt_o,       32'h0);
    next_cycle();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < RAND_CYCLES; c++) begin
      rst            = ($urandom_range(0, 249) == 0);
      flush_i        = ($urandom_range(0, 39) == 0);
      ex_mc_start_i  = ($urandom_range(0, 4) == 0);
      ex_mc_cycles_i = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) mem_req_i = ~mem_req_i;
      mem_ack_i      = ($urandom_range(0, 2) == 0);
      ex_is_load_i   = 1'($urandom_range(0, 1));
      ex_wreg_i      = ($urandom_range(0, 3) != 0);
      ex_wd_i        = 5'($urandom_range(0, 3));
      id_reg1_read_i = 1'($urandom_range(0, 1));
      id_reg1_addr_i = 5'($urandom_range(0, 3));
      id_reg2_read_i = 1'($urandom_range(0, 1));
      id_reg2_addr_i = 5'($urandom_range(0, 3));
      next_cycle();
    end

    clear_inputs();
    rst = 0;
    next_cycle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
